// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
// Contents:
//   NREGS      - number of architectural registers tracked by the scoreboard
//   regaddr_t  - 5-bit register address
//   ld_state_t - load FSM states (IDLE, LD_WAIT)
package pipe_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] regaddr_t;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } ld_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the decode/execute/memory/writeback control signals seen by
// pipe_ctrl.
// Modports:
//   master - drives run, id_*, ex_redirect, mem_ack, wb_*; observes outputs
//   slave  - pipe_ctrl side: consumes the above, drives issue, stall, flush,
//            ld_busy and stall_cnt
import pipe_pkg::*;

interface pipe_ctrl_if;

    logic        run;
    logic        id_valid;
    regaddr_t    id_rs1;
    regaddr_t    id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    regaddr_t    id_rd;
    logic        id_reg_we;
    logic        id_mem_re;
    logic        ex_redirect;
    logic        mem_ack;
    logic        wb_we;
    regaddr_t    wb_rd;

    logic        issue;
    logic        stall;
    logic        flush;
    logic        ld_busy;
    logic [31:0] stall_cnt;

    modport master (
        output run, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_we, id_mem_re, ex_redirect, mem_ack, wb_we, wb_rd,
        input  issue, stall, flush, ld_busy, stall_cnt
    );

    modport slave (
        input  run, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_we, id_mem_re, ex_redirect, mem_ack, wb_we, wb_rd,
        output issue, stall, flush, ld_busy, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a writer issues
// and cleared when the register file is written back.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   set_en, set_addr      - mark set_addr as pending (address 0 ignored)
//   clr_en, clr_addr      - mark clr_addr as no longer pending
//   rd_addr_a/b           - read port addresses
//   rd_pend_a/b           - registered pending bit for each read address
import pipe_pkg::*;

module scoreboard (
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  regaddr_t set_addr,
    input  logic     clr_en,
    input  regaddr_t clr_addr,
    input  regaddr_t rd_addr_a,
    input  regaddr_t rd_addr_b,
    output logic     rd_pend_a,
    output logic     rd_pend_b
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Clear is applied before set so a same-edge set/clear leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_en)
            pending_d[clr_addr] = 1'b0;
        if (set_en)
            pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign rd_pend_a = pending_q[rd_addr_a];
    assign rd_pend_b = pending_q[rd_addr_b];

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline issue control: RAW hazard scoreboard, blocking load FSM,
// redirect flush counter and a free-running stall-cycle counter.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   bus    - pipe_ctrl_if.slave (decode/EX/MEM/WB inputs; issue, stall,
//            flush, ld_busy, stall_cnt outputs)
// Parameter:
//   FLUSH_DEPTH - cycles flush stays high after a redirect (1..7)
// Configuration macro:
//   PIPE_CTRL_BYPASS_EN - when defined, a source being written back in the
//   same cycle is not a hazard (write-first register file).
import pipe_pkg::*;

module pipe_ctrl #(
    parameter int FLUSH_DEPTH = 2
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    ld_state_t   state_q, state_d;
    logic [2:0]  flush_cnt_q;
    logic [31:0] stall_cnt_q;

    logic pend_rs1, pend_rs2;
    logic hazard, issue, stall, flush, ld_busy;
    logic sb_set, sb_clr;

    assign sb_set = issue & bus.id_reg_we;
    assign sb_clr = bus.wb_we & bus.run;

    scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (sb_set),
        .set_addr  (bus.id_rd),
        .clr_en    (sb_clr),
        .clr_addr  (bus.wb_rd),
        .rd_addr_a (bus.id_rs1),
        .rd_addr_b (bus.id_rs2),
        .rd_pend_a (pend_rs1),
        .rd_pend_b (pend_rs2)
    );

`ifdef PIPE_CTRL_BYPASS_EN
    // A source retiring this cycle is forwarded by the write-first RF.
    logic byp_rs1, byp_rs2;
    assign byp_rs1 = sb_clr & (bus.wb_rd == bus.id_rs1);
    assign byp_rs2 = sb_clr & (bus.wb_rd == bus.id_rs2);
    assign hazard  = (bus.id_use_rs1 & pend_rs1 & ~byp_rs1) |
                     (bus.id_use_rs2 & pend_rs2 & ~byp_rs2);
`else
    assign hazard  = (bus.id_use_rs1 & pend_rs1) |
                     (bus.id_use_rs2 & pend_rs2);
`endif

    assign flush   = (flush_cnt_q != 3'd0);
    assign ld_busy = (state_q == LD_WAIT);
    assign issue   = bus.run & bus.id_valid & ~hazard & ~flush & ~ld_busy & ~reset;
    assign stall   = reset | (bus.id_valid & ~issue);

    // Load FSM: one outstanding load blocks issue until its data returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue & bus.id_mem_re)   state_d = LD_WAIT;
            LD_WAIT: if (bus.run & bus.mem_ack)   state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Redirect reloads the counter even mid-flush, extending the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_cnt_q <= 3'd0;
        else if (bus.run & bus.ex_redirect)
            flush_cnt_q <= FLUSH_LOAD;
        else if (bus.run && flush_cnt_q != 3'd0)
            flush_cnt_q <= flush_cnt_q - 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (bus.run & stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.flush     = flush;
    assign bus.ld_busy   = ld_busy;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (FLUSH_DEPTH = 2).
import pipe_pkg::*;

module tb_pipe_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.FLUSH_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef PIPE_CTRL_BYPASS_EN
    localparam logic BYP_ISSUE = 1'b1;
`else
    localparam logic BYP_ISSUE = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        bus.run         = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.id_rd       = '0;
        bus.id_reg_we   = 1'b0;
        bus.id_mem_re   = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.wb_we       = 1'b0;
        bus.wb_rd       = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        bus.id_valid = 1'b1;
        #2;
        n_vec++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL rst_issue got %b want 0", bus.issue); end
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got %b want 1", bus.stall); end
        n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got %b want 0", bus.flush); end
        n_vec++; if (bus.ld_busy !== 1'b0) begin n_err++; $display("FAIL rst_ld_busy got %b want 0", bus.ld_busy); end
        n_vec++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall_cnt got %h want 0", bus.stall_cnt); end
        step();
        idle();
        reset = 1'b0;
        #1;
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_release_stall got %b want 0", bus.stall); end
    endtask

    task automatic test_raw_hazard();
        idle();
        bus.id_valid = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd5;
        #1;
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL raw_producer_issue got %b want 1", bus.issue); end
        step();
        bus.id_reg_we = 1'b0; bus.id_rd = 5'd0; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL raw_consumer_stall got %b want 1", bus.stall); end
        step();
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL raw_consumer_stall2 got %b want 1", bus.stall); end
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5;
        #1;
        n_vec++; if (bus.issue !== BYP_ISSUE) begin n_err++; $display("FAIL raw_wb_cycle_issue got %b want %b", bus.issue, BYP_ISSUE); end
        step();
        bus.wb_we = 1'b0;
        #1;
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL raw_after_wb_issue got %b want 1", bus.issue); end
        step();
    endtask

    task automatic test_set_clear_same();
        idle();
        bus.id_valid = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd7;
        step();
        // pending[7] is set; clear and re-set it on the same edge
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7;
        #1;
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL setclr_issue got %b want 1", bus.issue); end
        step();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd7;
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL setclr_still_pending got %b want 1", bus.stall); end
        bus.id_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd7;
        step();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd7;
        #1;
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL setclr_cleared_issue got %b want 1", bus.issue); end
        step();
    endtask

    task automatic test_x0();
        idle();
        bus.id_valid = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd0;
        step();
        idle();
        bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd0;
        #1;
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got %b want 0", bus.stall); end
        n_vec++; if (dut.u_sb.pending_q[0] !== 1'b0) begin n_err++; $display("FAIL x0_pending got %b want 0", dut.u_sb.pending_q[0]); end
        step();
    endtask

    task automatic test_load();
        idle();
        bus.id_valid = 1'b1; bus.id_mem_re = 1'b1;
        #1;
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL ld_issue got %b want 1", bus.issue); end
        step();
        bus.id_mem_re = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.mem_ack = (k == 3);
            #1;
            n_vec++; if (bus.ld_busy !== 1'b1) begin n_err++; $display("FAIL ld_busy_c%0d got %b want 1", k, bus.ld_busy); end
            n_vec++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL ld_issue_c%0d got %b want 0", k, bus.issue); end
            step();
        end
        bus.mem_ack = 1'b0;
        #1;
        n_vec++; if (bus.ld_busy !== 1'b0) begin n_err++; $display("FAIL ld_done_busy got %b want 0", bus.ld_busy); end
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL ld_done_issue got %b want 1", bus.issue); end
        idle();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        #1;
        n_vec++; if (bus.ld_busy !== 1'b0) begin n_err++; $display("FAIL ld_idle_ack got %b want 0", bus.ld_busy); end
    endtask

    task automatic test_flush();
        int cnt;
        idle();
        bus.id_valid = 1'b1; bus.ex_redirect = 1'b1;
        #1;
        n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL flush_pre got %b want 0", bus.flush); end
        step();
        bus.ex_redirect = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.flush === 1'b1) begin
                cnt++;
                n_vec++; if (bus.issue !== 1'b0) begin n_err++; $display("FAIL flush_issue_c%0d got %b want 0", i, bus.issue); end
            end
            step();
        end
        n_vec++; if (cnt !== 2) begin n_err++; $display("FAIL flush_len got %0d want 2", cnt); end
        // second pulse lands in the first flush cycle
        bus.ex_redirect = 1'b1;
        step();
        cnt = 0;
        #1;
        if (bus.flush === 1'b1) cnt++;
        step();
        bus.ex_redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.flush === 1'b1) cnt++;
            step();
        end
        n_vec++; if (cnt !== 3) begin n_err++; $display("FAIL flush_extend_len got %0d want 3", cnt); end
    endtask

    task automatic test_redirect_load();
        idle();
        bus.id_valid = 1'b1; bus.id_mem_re = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd9;
        step();
        idle();
        bus.ex_redirect = 1'b1;
        step();
        bus.ex_redirect = 1'b0;
        step();
        step();
        #1;
        n_vec++; if (bus.ld_busy !== 1'b1) begin n_err++; $display("FAIL redir_keeps_load got %b want 1", bus.ld_busy); end
        n_vec++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL redir_flush_done got %b want 0", bus.flush); end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd9;
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL redir_keeps_pending got %b want 1", bus.stall); end
        bus.id_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd9;
        step();
        idle();
    endtask

    task automatic test_reset_mid_load();
        idle();
        bus.id_valid = 1'b1; bus.id_mem_re = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd5;
        step();
        idle();
        #1;
        n_vec++; if (dut.u_sb.pending_q !== 32'h0000_0020) begin n_err++; $display("FAIL rml_pending_pre got %h want 00000020", dut.u_sb.pending_q); end
        n_vec++; if (bus.ld_busy !== 1'b1) begin n_err++; $display("FAIL rml_busy_pre got %b want 1", bus.ld_busy); end
        reset = 1'b1;
        #1;
        n_vec++; if (dut.u_sb.pending_q !== 32'h0) begin n_err++; $display("FAIL rml_pending got %h want 0", dut.u_sb.pending_q); end
        n_vec++; if (bus.ld_busy !== 1'b0) begin n_err++; $display("FAIL rml_busy got %b want 0", bus.ld_busy); end
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rml_stall got %b want 1", bus.stall); end
        n_vec++; if (bus.stall_cnt !== 32'd0) begin n_err++; $display("FAIL rml_stall_cnt got %h want 0", bus.stall_cnt); end
        step();
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
        #1;
        n_vec++; if (bus.ld_busy !== 1'b0) begin n_err++; $display("FAIL rml_late_ack got %b want 0", bus.ld_busy); end
        n_vec++; if (bus.issue !== 1'b1) begin n_err++; $display("FAIL rml_issue_after got %b want 1", bus.issue); end
        step();
        idle();
    endtask

    task automatic test_stall_cnt_wrap();
        logic [31:0] exp_cnt [5];
        exp_cnt[0] = 32'hFFFF_FFFE; exp_cnt[1] = 32'hFFFF_FFFE;
        exp_cnt[2] = 32'hFFFF_FFFF; exp_cnt[3] = 32'hFFFF_FFFF;
        exp_cnt[4] = 32'h0000_0000;
        idle();
        bus.id_valid = 1'b1; bus.id_reg_we = 1'b1; bus.id_rd = 5'd3;
        step();
        idle();
        bus.run = 1'b0;
        bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd3;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        step();
        n_vec++; if (bus.stall_cnt !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL sc_hold got %h want fffffffd", bus.stall_cnt); end
        for (int i = 0; i < 5; i++) begin
            bus.run   = (i % 2 == 0);
            // a writeback while halted must not retire the pending bit
            bus.wb_we = (i % 2 == 1);
            bus.wb_rd = 5'd3;
            step();
            n_vec++; if (bus.stall_cnt !== exp_cnt[i]) begin n_err++; $display("FAIL sc_step%0d got %h want %h", i, bus.stall_cnt, exp_cnt[i]); end
        end
        bus.run = 1'b1; bus.wb_we = 1'b0;
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL sc_pending_held got %b want 1", bus.stall); end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_raw_hazard();
        test_set_clear_same();
        test_x0();
        test_load();
        test_flush();
        test_redirect_load();
        test_reset_mid_load();
        test_stall_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, giving the number of cycles flush is held after a redirect (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port run, input, 1, core enable; when 0, all state holds and no issue occurs.
REQ-005 SHALL have port id_valid, input, 1, decode stage holds a valid instruction.
REQ-006 SHALL have ports id_rs1, id_rs2, input, 5 each, decode source register addresses.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2, input, 1 each, the corresponding source is read.
REQ-008 SHALL have ports id_rd (input, 5) and id_reg_we (input, 1), the decode destination and its write enable.
REQ-009 SHALL have port id_mem_re, input, 1, the decode instruction is a load.
REQ-010 SHALL have port ex_redirect, input, 1, taken branch/jal/jalr resolved in EX.
REQ-011 SHALL have port mem_ack, input, 1, data memory returns load data.
REQ-012 SHALL have ports wb_we (input, 1) and wb_rd (input, 5), the register-file write port.
REQ-013 SHALL have outputs issue, stall, flush and ld_busy (1 each), plus stall_cnt (32).

Function
REQ-014 SHALL keep a 32-bit pending scoreboard; bit 0 is never set.
REQ-015 issue SHALL = run & id_valid & ~hazard & ~flush & ~ld_busy & ~reset.
REQ-016 hazard SHALL = (id_use_rs1 & pending[id_rs1]) | (id_use_rs2 & pending[id_rs2]).
REQ-017 stall SHALL = reset | (id_valid & ~issue).
REQ-018 On the clock edge with issue & id_reg_we & id_rd!=0, pending[id_rd] SHALL be set.
REQ-019 On the clock edge with wb_we & run, pending[wb_rd] SHALL be cleared.
REQ-020 A set and a clear of the same register on one edge SHALL leave it set.
REQ-021 The load FSM SHALL have states IDLE and LD_WAIT; issue & id_mem_re moves IDLE->LD_WAIT; mem_ack in LD_WAIT moves it to IDLE; mem_ack in IDLE is ignored.
REQ-022 ld_busy SHALL = (state == LD_WAIT).
REQ-023 ex_redirect & run SHALL load a 3-bit flush counter with FLUSH_DEPTH.
REQ-024 While run is 1 and the counter is nonzero, and ex_redirect is 0, the counter SHALL decrement by 1 per cycle.
REQ-025 flush SHALL be 1 exactly while the counter is nonzero.
REQ-026 A redirect while the counter is nonzero SHALL reload the counter.
REQ-027 A redirect during LD_WAIT SHALL NOT cancel the load; the FSM still waits for mem_ack.
REQ-028 ex_redirect SHALL NOT clear pending bits.
REQ-029 stall_cnt SHALL increment by 1 on each edge with run & stall and wrap from 0xFFFFFFFF to 0.
REQ-030 With run=0, the scoreboard, FSM, counter and stall_cnt SHALL hold.

Reset
REQ-031 On reset, asynchronously: pending=0, FSM=IDLE, flush counter=0, stall_cnt=0.
REQ-032 While reset is asserted: issue=0, stall=1, flush=0, ld_busy=0.
REQ-033 Reset in LD_WAIT SHALL return to IDLE; any later mem_ack is ignored.

Configuration
REQ-034 Macro PIPE_CTRL_BYPASS_EN defined: a source whose pending bit is cleared by wb_we/wb_rd in the same cycle SHALL NOT count as a hazard (write-first register file).
REQ-035 Macro PIPE_CTRL_BYPASS_EN undefined: hazard SHALL use the registered pending bit only (one extra stall cycle).

Structure
REQ-036 Package pipe_pkg SHALL hold typedef regaddr_t (5-bit), enum ld_state_t {IDLE, LD_WAIT} and constant NREGS=32.
REQ-037 The scoreboard SHALL be sub-module scoreboard (set port, clear port, two read ports); all else stays in pipe_ctrl.

Verification
REQ-038 Scenario: issue "rd=5, we", then a consumer with rs1=5 -> stall=1 until wb_we/wb_rd=5; issue in that cycle with BYPASS_EN, the next cycle without.
REQ-039 Scenario: issue a load with mem_ack delayed 3 cycles -> ld_busy=1 for 3 cycles, issue=0 throughout, IDLE after the ack.
REQ-040 Scenario: ex_redirect pulse with FLUSH_DEPTH=2 -> flush=1 for exactly 2 cycles; a second pulse on cycle 2 extends flush to 3 cycles total.
REQ-041 Scenario: id_rd=0 with we, then rs1=0 -> no stall, pending[0] stays 0.
REQ-042 Scenario: assert reset mid-LD_WAIT with pending=0x20 -> pending=0, ld_busy=0, stall=1 during reset, stall_cnt=0.
REQ-043 Scenario: preload stall_cnt near wrap via a long hazard with run toggling -> the count advances only on run cycles and wraps to 0.
